ysyx_dmem_resp: RTL and testbench

Data-memory responder for the ysyx core: the target end of the load/store path that the execute stage drives. It accepts one word-granular read or byte-masked write per transaction over a valid/ready request channel, models a fixed access latency, and returns read data or write completion on a valid/ready response channel. It sits between the core's load/store issue logic and an internal synchronous word array. It replaces direct memory calls with a cycle-accurate, verifiable slave.

---
 rtl/ysyx_dmem_resp.sv | 225 ++++++++++++++++++++++
 tb/tb_ysyx_dmem_resp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_dmem_resp
// Purpose  : Data-memory responder for the ysyx load/store path. Accepts one
//            word-granular read or byte-masked write per transaction on a
//            valid/ready request channel, waits a fixed number of cycles,
//            then returns read data / write completion on a valid/ready
//            response channel. Backed by an internal synchronous word array.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   BASE         byte address of word 0
//   DEPTH_LOG2   log2 of the number of 32-bit words in the array
//   LATENCY      wait cycles between request acceptance and response (0..15)
// Ports
//   clk, rst_n        clock / asynchronous active-low reset
//   i_req_valid       request present
//   o_req_ready       responder idle and able to accept a request
//   i_req_wen         1 = write, 0 = read
//   i_req_addr        byte address (bits [1:0] ignored)
//   i_req_wdata       write data
//   i_req_wmask       byte-lane enables for writes
//   o_resp_valid      response present
//   i_resp_ready      initiator accepts response
//   o_resp_rdata      read data (0 for writes and out-of-range accesses)
//   o_resp_err        address outside the array window
// Build option
//   DMEM_RAND_DELAY_EN  adds 0..3 pseudo-random wait cycles per transaction
//                       from an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5).
// ============================================================================
module ysyx_dmem_resp #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wmask,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int C_DEPTH = 1 << DEPTH_LOG2;
    localparam int C_AW    = DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;

    // Transaction captured at the accepting edge
    logic              r_wen;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wmask;
    logic [C_AW-1:0]   r_idx;
    logic              r_in_range;

    logic [31:0]       r_mem [C_DEPTH];

    // ------------------------------------------------------------------
    // Request decode. The offset form of the range check avoids overflow
    // of BASE + window size near the top of the address space.
    // ------------------------------------------------------------------
    logic [31:0]       w_off;
    logic              w_in_range;
    logic [C_AW-1:0]   w_idx;

    assign w_off      = i_req_addr - BASE;
    assign w_in_range = (i_req_addr >= BASE) && ((w_off >> (C_AW + 2)) == 32'd0);
    assign w_idx      = w_off[C_AW+1:2];

    // ------------------------------------------------------------------
    // Extra wait cycles
    // ------------------------------------------------------------------
    logic [1:0]        w_extra;
`ifdef DMEM_RAND_DELAY_EN
    logic [7:0]        r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_extra = r_lfsr[1:0];
`else
    assign w_extra = 2'd0;
`endif

    // Total wait cycles between the accepting edge and the commit edge
    logic [4:0]        w_wait;
    assign w_wait = 5'(LATENCY) + {3'b000, w_extra};

    // ------------------------------------------------------------------
    // Commit point. With zero wait the accepting edge is also the commit
    // edge, so the transaction comes straight from the request inputs;
    // otherwise it comes from the registers latched at acceptance.
    // ------------------------------------------------------------------
    logic              w_commit_now;
    logic              w_commit_wait;
    logic              w_commit;
    logic              w_cm_wen;
    logic              w_cm_in;
    logic [C_AW-1:0]   w_cm_idx;
    logic [31:0]       w_cm_wdata;
    logic [3:0]        w_cm_wmask;
    logic              w_mem_we;
    logic [31:0]       w_rd_word;

    assign w_commit_now  = (r_state == S_IDLE) && i_req_valid && (w_wait == 5'd0);
    assign w_commit_wait = (r_state == S_WAIT) && (r_cnt == 5'd0);
    // rst_n gate keeps a held-in-reset request from writing the array
    assign w_commit      = rst_n && (w_commit_now || w_commit_wait);

    assign w_cm_wen   = w_commit_now ? i_req_wen   : r_wen;
    assign w_cm_in    = w_commit_now ? w_in_range  : r_in_range;
    assign w_cm_idx   = w_commit_now ? w_idx       : r_idx;
    assign w_cm_wdata = w_commit_now ? i_req_wdata : r_wdata;
    assign w_cm_wmask = w_commit_now ? i_req_wmask : r_wmask;

    assign w_mem_we   = w_commit && w_cm_wen && w_cm_in;
    assign w_rd_word  = (!w_cm_wen && w_cm_in) ? r_mem[w_cm_idx] : 32'd0;

    // ------------------------------------------------------------------
    // Word array: contents are intentionally not reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_cm_wmask[b]) begin
                    r_mem[w_cm_idx][8*b +: 8] <= w_cm_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 5'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_wen        <= 1'b0;
            r_wdata      <= 32'd0;
            r_wmask      <= 4'd0;
            r_idx        <= '0;
            r_in_range   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_wen       <= i_req_wen;
                        r_wdata     <= i_req_wdata;
                        r_wmask     <= i_req_wmask;
                        r_idx       <= w_idx;
                        r_in_range  <= w_in_range;
                        r_req_ready <= 1'b0;
                        if (w_wait == 5'd0) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_rd_word;
                            r_resp_err   <= !w_cm_in;
                        end else begin
                            r_cnt   <= w_wait - 5'd1;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 5'd0) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_rd_word;
                        r_resp_err   <= !w_cm_in;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= S_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_dmem_resp
// Purpose  : Self-checking bench for ysyx_dmem_resp. Directed scenarios plus
//            randomized transactions checked against a word-map reference of
//            the memory window and the expected response latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_dmem_resp;

    localparam logic [31:0] BASE       = 32'h8000_0000;
    localparam int          DEPTH_LOG2 = 10;
    localparam int          LATENCY    = 1;
    localparam longint      WIN_BYTES  = 4 * (64'd1 << DEPTH_LOG2);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wen;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_wmask;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;

    int vectors = 0;
    int fails   = 0;

    // Reference: word offset -> word value
    logic [31:0] mdl [int];

    ysyx_dmem_resp #(
        .BASE       (BASE),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LATENCY    (LATENCY)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_wen    (i_req_wen),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .i_req_wmask  (i_req_wmask),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_rdata (o_resp_rdata),
        .o_resp_err   (o_resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return (a >= longint'(BASE)) && (a < longint'(BASE) + WIN_BYTES);
    endfunction

    // One complete transaction; hold = cycles of response backpressure,
    // during which a stray write to junk_addr is presented and must be ignored.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input int hold, input logic [31:0] junk_addr);
        bit          in;
        int          key;
        int          cyc;
        logic [31:0] exp_rd;
        logic [31:0] tmp;
        logic [31:0] held;
        in     = in_win(addr);
        key    = int'((addr - BASE) >> 2);
        exp_rd = (!wen && in) ? mdl[key] : 32'd0;

        @(negedge clk);
        chk("req_ready_idle", {31'd0, o_req_ready}, 32'd1);
        i_req_valid = 1'b1;
        i_req_wen   = wen;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_req_wmask = wmask;
        @(negedge clk);
        i_req_valid = 1'b0;
        cyc = 1;
        while (!o_resp_valid && cyc < LATENCY + 10) begin
            @(negedge clk);
            cyc++;
        end
`ifdef DMEM_RAND_DELAY_EN
        chk("latency_window", {31'd0, (cyc >= LATENCY + 1) && (cyc <= LATENCY + 4)}, 32'd1);
`else
        chk("latency", cyc, LATENCY + 1);
`endif
        chk("resp_valid", {31'd0, o_resp_valid}, 32'd1);
        chk("resp_rdata", o_resp_rdata, exp_rd);
        chk("resp_err", {31'd0, o_resp_err}, {31'd0, !in});
        chk("req_ready_busy", {31'd0, o_req_ready}, 32'd0);

        if (wen && in) begin
            tmp = mdl[key];
            for (int b = 0; b < 4; b++)
                if (wmask[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
            mdl[key] = tmp;
        end

        held = o_resp_rdata;
        for (int h = 0; h < hold; h++) begin
            i_req_valid = 1'b1;
            i_req_wen   = 1'b1;
            i_req_addr  = junk_addr;
            i_req_wdata = $urandom;
            i_req_wmask = 4'hF;
            @(negedge clk);
            chk("bp_valid", {31'd0, o_resp_valid}, 32'd1);
            chk("bp_rdata", o_resp_rdata, held);
            chk("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
        end

        // Handshake; a request still presented here must not be accepted
        i_resp_ready = 1'b1;
        @(negedge clk);
        i_resp_ready = 1'b0;
        i_req_valid  = 1'b0;
        chk("post_hs_valid", {31'd0, o_resp_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, o_req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        int          w;
        rst_n        = 1'b0;
        i_req_valid  = 1'b1;
        i_req_wen    = 1'b1;
        i_req_addr   = BASE;
        i_req_wdata  = 32'hFFFF_FFFF;
        i_req_wmask  = 4'hF;
        i_resp_ready = 1'b0;

        // Reset held with a request present
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
        chk("rst_resp_rdata", o_resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, o_resp_err}, 32'd0);
        i_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Prime words 0..17
        for (int i = 0; i < 18; i++)
            txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, BASE);

        // Full write then read
        txn(1'b1, 32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, BASE);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, BASE);
        chk("deadbeef_model", mdl[4], 32'hDEADBEEF);

        // Partial write
        txn(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, BASE);
        txn(1'b1, 32'h8000_0020, 32'h0000_5500, 4'b0010, 0, BASE);
        txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, BASE);
        txn(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 0, BASE); // no-op write
        txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, BASE);

        // Out-of-range reads and a write that must not alias onto word 0
        txn(1'b0, 32'h8000_1000, 32'h0, 4'h0, 0, BASE);
        txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, BASE);
        txn(1'b1, 32'h8000_1000, 32'hA5A5_A5A5, 4'hF, 0, BASE);
        txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, BASE);

        // Backpressure with an ignored stray write to word 5
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, 32'h8000_0014);
        txn(1'b0, 32'h8000_0014, 32'h0, 4'h0, 0, BASE);

        // Reset during the wait of a write: array keeps old word
        txn(1'b1, 32'h8000_0040, 32'h0, 4'hF, 0, BASE);
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_wen   = 1'b1;
        i_req_addr  = 32'h8000_0040;
        i_req_wdata = 32'hFFFF_FFFF;
        i_req_wmask = 4'hF;
        @(negedge clk);
        i_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, o_resp_valid}, 32'd0);
        chk("midrst_ready", {31'd0, o_req_ready}, 32'd1);
        chk("midrst_rdata", o_resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, BASE);

        // Reset held with a write presented: no array write
        @(negedge clk);
        rst_n       = 1'b0;
        i_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rsthold_valid", {31'd0, o_resp_valid}, 32'd0);
        i_req_valid = 1'b0;
        rst_n       = 1'b1;
        txn(1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, BASE);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            w = int'($urandom_range(0, 17));
            case ($urandom_range(0, 7))
                0:       a = BASE + 32'(WIN_BYTES) + 32'(4 * w);
                1:       a = BASE - 32'(4 * (w + 1));
                default: a = BASE + 32'(4 * w);
            endcase
            a[1:0] = 2'($urandom);
            txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                BASE + 32'(4 * $urandom_range(0, 17)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
